// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run controller.
// State encoding, status codes and the ebreak instruction word.
package run_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [2:0] STATUS_RUNNING = 3'd0;
    localparam logic [2:0] STATUS_GOOD    = 3'd1;
    localparam logic [2:0] STATUS_BAD     = 3'd2;
    localparam logic [2:0] STATUS_TIMEOUT = 3'd3;
    localparam logic [2:0] STATUS_HANG    = 3'd4;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    function automatic logic is_ebreak(input logic [31:0] inst);
        return (inst == EBREAK_INST);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Count register: clear has priority over increment
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= '0;
        end else if (clr) begin
            q_r <= '0;
        end else if (inc && (q_r != {W{1'b1}})) begin
            q_r <= q_r + W'(1);
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/run_ctrl.sv
// Simulation run controller: gates the core, counts cycles/retirements and latches exit status.
// Optional RUN_CTRL_SIM_FINISH_EN: report and call $finish on entry to DONE.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int CYC_W        = 32,
    parameter int MAX_CYCLES   = 1000000,
    parameter int STALL_LIMIT  = 64,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inst_valid,
    input  logic [31:0]      inst,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  a0,
    output logic             run,
    output logic             done,
    output logic [2:0]       status,
    output logic [XLEN-1:0]  exit_code,
    output logic [CYC_W-1:0] cycles,
    output logic [CYC_W-1:0] instret
);

    localparam int STALL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) + 1 : 1;

    state_e           state_r, state_s;
    logic [3:0]       drain_r, drain_s;
    logic [2:0]       status_r, status_s;
    logic [XLEN-1:0]  exit_code_r, exit_code_s;
    logic             done_r, done_s;
    logic             run_r, run_s;
    logic [XLEN-1:0]  last_pc_r;
    logic [STALL_W-1:0] stall_q_s;
    logic [CYC_W-1:0] cycles_q_s;
    logic [CYC_W-1:0] instret_q_s;

    logic in_run_s, retire_s, trap_s, hang_s, tmo_s, progress_s;

    assign in_run_s   = (state_r == ST_RUN);
    assign retire_s   = in_run_s && inst_valid;
    assign trap_s     = retire_s && is_ebreak(inst);
    assign progress_s = retire_s && (pc != last_pc_r);
    assign hang_s     = (STALL_LIMIT != 0) && (stall_q_s == STALL_W'(STALL_LIMIT - 1));
    assign tmo_s      = (MAX_CYCLES != 0) && (cycles_q_s == CYC_W'(MAX_CYCLES - 1));

    sat_counter #(.W(CYC_W)) u_cycles (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (in_run_s), .q (cycles_q_s)
    );

    sat_counter #(.W(CYC_W)) u_instret (
        .clk (clk), .rst (rst), .clr (1'b0), .inc (retire_s), .q (instret_q_s)
    );

    // Stall counter restarts only when a retirement lands on a different PC
    sat_counter #(.W(STALL_W)) u_stall (
        .clk (clk), .rst (rst), .clr (progress_s), .inc (in_run_s), .q (stall_q_s)
    );

    // PC of the most recent retirement, used to spot a tight self-loop
    always_ff @(posedge clk) begin
        if (rst) begin
            last_pc_r <= '0;
        end else if (retire_s) begin
            last_pc_r <= pc;
        end else begin
            last_pc_r <= last_pc_r;
        end
    end

    // Next-state and next-output logic; stop events resolve trap > hang > timeout
    always_comb begin
        state_s     = state_r;
        drain_s     = drain_r;
        status_s    = status_r;
        exit_code_s = exit_code_r;
        done_s      = done_r;
        run_s       = run_r;
        case (state_r)
            ST_IDLE: begin
                state_s = ST_RUN;
                run_s   = 1'b1;
            end
            ST_RUN: begin
                if (trap_s || hang_s || tmo_s) begin
                    state_s = ST_DRAIN;
                    run_s   = 1'b0;
                    drain_s = 4'(DRAIN_CYCLES);
                    if (trap_s) begin
                        exit_code_s = a0;
                        status_s    = (a0 == '0) ? STATUS_GOOD : STATUS_BAD;
                    end else if (hang_s) begin
                        status_s = STATUS_HANG;
                    end else begin
                        status_s = STATUS_TIMEOUT;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_r == 4'd0) begin
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else begin
                    drain_s = drain_r - 4'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
                run_s   = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            drain_r     <= 4'd0;
            status_r    <= STATUS_RUNNING;
            exit_code_r <= '0;
            done_r      <= 1'b0;
            run_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            drain_r     <= drain_s;
            status_r    <= status_s;
            exit_code_r <= exit_code_s;
            done_r      <= done_s;
            run_r       <= run_s;
        end
    end

`ifdef RUN_CTRL_SIM_FINISH_EN
    // Report the outcome and end simulation on the DRAIN -> DONE transition
    always_ff @(posedge clk) begin
        if (!rst && (state_r == ST_DRAIN) && (state_s == ST_DONE)) begin
            $display("[run_ctrl] status=%0d exit_code=%0d cycles=%0d instret=%0d",
                     status_r, exit_code_r, cycles_q_s, instret_q_s);
            if (status_r == STATUS_GOOD) begin
                $display("*-* All Finished *-*");
            end
            $finish;
        end
    end
`endif

    assign run       = run_r;
    assign done      = done_r;
    assign status    = status_r;
    assign exit_code = exit_code_r;
    assign cycles    = cycles_q_s;
    assign instret   = instret_q_s;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: directed and random runs scored cycle by cycle against a timeline model.
module tb_run_ctrl;

    localparam int XLEN    = 32;
    localparam int CYC_W   = 32;
    localparam int MAX_C   = 20;
    localparam int STALL_L = 8;
    localparam int DRAIN_C = 2;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             inst_valid = 1'b0;
    logic [31:0]      inst = 32'h0;
    logic [XLEN-1:0]  pc = '0;
    logic [XLEN-1:0]  a0 = '0;
    logic             run, done;
    logic [2:0]       status;
    logic [XLEN-1:0]  exit_code;
    logic [CYC_W-1:0] cycles, instret;

    always #5 clk = ~clk;

    run_ctrl #(
        .XLEN(XLEN), .CYC_W(CYC_W), .MAX_CYCLES(MAX_C),
        .STALL_LIMIT(STALL_L), .DRAIN_CYCLES(DRAIN_C)
    ) dut (
        .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst(inst), .pc(pc), .a0(a0),
        .run(run), .done(done), .status(status), .exit_code(exit_code),
        .cycles(cycles), .instret(instret)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a run is "idle for one edge, then active until a stop, then time since stop"
    bit          m_idle = 1'b1;
    bit          m_active = 1'b0;
    int          m_since = -1;
    logic [2:0]  m_status = 3'd0;
    logic [31:0] m_code = 32'd0;
    int          m_cycles = 0;
    int          m_instret = 0;
    int          m_stall = 0;
    logic [31:0] m_last_pc = 32'd0;

    task automatic model_edge();
        bit trap, hang, tmo;
        if (rst) begin
            m_idle = 1'b1; m_active = 1'b0; m_since = -1;
            m_status = 3'd0; m_code = 32'd0;
            m_cycles = 0; m_instret = 0; m_stall = 0; m_last_pc = 32'd0;
        end else if (m_idle) begin
            m_idle = 1'b0; m_active = 1'b1;
        end else if (m_active) begin
            trap = inst_valid && (inst == EBREAK);
            hang = (m_stall == STALL_L - 1);
            tmo  = (m_cycles == MAX_C - 1);
            m_cycles++;
            if (inst_valid) m_instret++;
            if (inst_valid && (pc != m_last_pc)) m_stall = 0;
            else m_stall++;
            if (inst_valid) m_last_pc = pc;
            if (trap || hang || tmo) begin
                m_active = 1'b0;
                m_since = 0;
                if (trap) begin
                    m_code = a0;
                    m_status = (a0 == 32'd0) ? 3'd1 : 3'd2;
                end else if (hang) m_status = 3'd4;
                else m_status = 3'd3;
            end
        end else if (m_since >= 0) begin
            m_since++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("run", run, m_active);
        check_eq("done", done, (m_since >= 1 + DRAIN_C));
        check_eq("status", status, m_status);
        check_eq("exit_code", exit_code, m_code);
        check_eq("cycles", cycles, m_cycles);
        check_eq("instret", instret, m_instret);
    endtask

    // Stimulus per scenario; k is the number of the upcoming RUN cycle
    task automatic drive(input int kind);
        int k;
        k = m_cycles + 1;
        if (!m_active && kind != 6) begin
            inst_valid = 1'b1; inst = EBREAK; pc = 32'h44; a0 = 32'd7;
            return;
        end
        case (kind)
            0: begin inst_valid = 1'b1; pc = 32'(k * 4); inst = (k == 10) ? EBREAK : NOP; a0 = 32'd0; end
            1: begin inst_valid = 1'b1; pc = 32'(k * 4); inst = (k == 6) ? EBREAK : NOP; a0 = 32'd5; end
            2: begin inst_valid = 1'b1; pc = 32'(k * 4); inst = NOP; a0 = 32'd3; end
            3: begin inst_valid = 1'b1; pc = 32'h80; inst = NOP; a0 = 32'd0; end
            4: begin inst_valid = 1'b0; pc = 32'h80; inst = NOP; a0 = 32'd0; end
            5: begin
                inst_valid = (k <= 12) || (k == 20);
                pc = 32'(k * 4);
                inst = (k == 20) ? EBREAK : NOP;
                a0 = 32'd0;
            end
            8: begin inst_valid = 1'b1; pc = 32'h100; inst = EBREAK; a0 = 32'd0; end
            default: begin
                inst_valid = 1'($urandom_range(0, 1));
                pc = 32'($urandom_range(1, 3) * 4);
                inst = ($urandom_range(0, 15) == 0) ? EBREAK : NOP;
                a0 = 32'($urandom_range(0, 2));
            end
        endcase
    endtask

    task automatic run_case(input int kind, input bit rst_in_drain);
        bit did_rst;
        did_rst = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 80; i++) begin
            drive(kind);
            if (rst_in_drain && !did_rst && (m_since == 1)) begin
                rst = 1'b1;
                did_rst = 1'b1;
            end else begin
                rst = 1'b0;
            end
            step();
            if (m_since >= DRAIN_C + 4) break;
        end
        // Absolute end-of-run values straight from the scenario definitions
        case (kind)
            0: begin check_eq("trap_good_status", status, 3'd1); check_eq("trap_good_cycles", cycles, 32'd10); end
            1: begin check_eq("trap_bad_status", status, 3'd2); check_eq("trap_bad_code", exit_code, 32'd5); end
            2: begin check_eq("timeout_status", status, 3'd3); check_eq("timeout_cycles", cycles, 32'd20);
                     check_eq("timeout_instret", instret, 32'd20); end
            3: begin check_eq("hang_pc_status", status, 3'd4); check_eq("hang_pc_cycles", cycles, 32'd9); end
            4: begin check_eq("hang_idle_status", status, 3'd4); check_eq("hang_idle_cycles", cycles, 32'd8); end
            5: begin check_eq("coincide_status", status, 3'd1); check_eq("coincide_cycles", cycles, 32'd20); end
            8: begin check_eq("first_ebreak_cycles", cycles, 32'd1); check_eq("first_ebreak_instret", instret, 32'd1); end
            default: check_eq("random_done", done, 1'b1);
        endcase
    endtask

    initial begin
        run_case(0, 1'b0);
        run_case(1, 1'b0);
        run_case(2, 1'b0);
        run_case(3, 1'b0);
        run_case(4, 1'b0);
        run_case(5, 1'b0);
        run_case(8, 1'b0);
        run_case(0, 1'b1);
        for (int r = 0; r < 25; r++) begin
            run_case(6, 1'b0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
